// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART byte sender among NUM_REQ requesters.
// A winning byte is latched and acked, the sender is strobed, and the arbiter
// then waits for the sender's busy flag to rise and fall before serving again.
// If busy never rises, the byte is dropped and err_timeout pulses.
// All outputs are registered and are loaded on the edge that enters the state
// they belong to. ack is therefore high during GRANT, and tx_start is high
// during ISSUE.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_start,
  input  logic                      tx_busy,
  output logic [2:0]                active_id,
  output logic                      err_timeout
);

  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [NUM_REQ-1:0] ACK_LSB  = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GRANT   = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_WAIT_LO = 3'd4
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [2:0]        rr_ptr_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              win_found_s;
  logic [2:0]        win_idx_s;
  logic [2:0]        next_ptr_s;
  logic [DATA_W-1:0] win_data_s;
  logic              timeout_s;

  // Round-robin search from rr_ptr upward with wrap. The loop scans downward,
  // so the last hit is the candidate nearest to the pointer.
  always_comb begin : pick_winner
    int cand;
    cand        = 0;
    win_found_s = 1'b0;
    win_idx_s   = 3'd0;
    win_data_s  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand        = (int'(rr_ptr_r) + k) % NUM_REQ;
      win_idx_s   = req[cand] ? 3'(cand) : win_idx_s;
      win_found_s = win_found_s | req[cand];
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      win_data_s = (3'(i) == win_idx_s) ? req_data[i*DATA_W +: DATA_W] : win_data_s;
    end
    next_ptr_s = (int'(win_idx_s) == NUM_REQ - 1) ? 3'd0 : win_idx_s + 3'd1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic. Requests are only looked at in IDLE, and only while
  // the sender is free.
  always_comb begin
    state_s   = state_r;
    timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (win_found_s && !tx_busy) begin
          state_s = ST_GRANT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GRANT: state_s = ST_ISSUE;
      ST_ISSUE: state_s = ST_WAIT_HI;
      ST_WAIT_HI: begin
        if (tx_busy) begin
          state_s = ST_WAIT_LO;
        end else if (cnt_r == LAST_CNT) begin
          state_s   = ST_IDLE;
          timeout_s = 1'b1;
        end else begin
          state_s = ST_WAIT_HI;
        end
      end
      ST_WAIT_LO: begin
        if (!tx_busy) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT_LO;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Registered outputs, round-robin pointer and busy-wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack         <= '0;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      active_id   <= 3'd0;
      err_timeout <= 1'b0;
      rr_ptr_r    <= 3'd0;
      cnt_r       <= '0;
    end else begin
      ack         <= '0;
      tx_start    <= 1'b0;
      err_timeout <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (state_s == ST_GRANT) begin
            ack       <= ACK_LSB << win_idx_s;
            tx_data   <= win_data_s;
            active_id <= win_idx_s;
            rr_ptr_r  <= next_ptr_s;
          end
        end
        ST_GRANT: tx_start <= 1'b1;
        ST_ISSUE: cnt_r <= '0;
        ST_WAIT_HI: begin
          err_timeout <= timeout_s;
          if (state_s == ST_WAIT_HI) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter.
// The reference is transaction level: a round-robin pointer plus the documented
// cycle latencies. Each transfer is predicted from those rules and then
// compared cycle by cycle.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int DATA_W       = 8;
  localparam int BUSY_TIMEOUT = 16;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [2:0]  active_id;
  logic        err_timeout;

  int errors;
  int checks;
  int exp_ptr;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .active_id(active_id), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Abort guard: the bench must never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [13:0] obs();
    return {ack, tx_start, err_timeout, tx_data};
  endfunction

  function automatic logic [13:0] quiet(input logic [7:0] b);
    return {4'b0000, 1'b0, 1'b0, b};
  endfunction

  // Round-robin rule: the first set bit at or above ptr, wrapping around.
  function automatic int rr_pick(input logic [3:0] pat, input int ptr);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pat[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  // One transfer, called in a cycle where the arbiter is idle.
  // delay == 0 models a sender that never goes busy.
  // The task returns in the first idle cycle after the transfer.
  task automatic run_xfer(input logic [3:0] pat, input logic [31:0] data, input int delay,
                          input int len, input bit noise, input bit hold);
    int         win;
    logic [7:0] b;
    logic [3:0] one;
    req      = pat;
    req_data = data;
    if (pat == 4'b0000) begin
      for (int i = 0; i < 3; i++) begin
        tick();
        check_eq("no_req_ack", {28'd0, ack}, 32'd0);
      end
      return;
    end
    win = rr_pick(pat, exp_ptr);
    b   = data[win*8 +: 8];
    one = 4'b0001 << win;
    tick();
    check_eq("grant", {18'd0, obs()}, {18'd0, one, 1'b0, 1'b0, b});
    check_eq("active_id", {29'd0, active_id}, 32'(win));
    exp_ptr = (win + 1) % NUM_REQ;
    if (!hold) req = noise ? 4'($urandom) : 4'b0000;
    tick();
    check_eq("issue", {18'd0, obs()}, {18'd0, 4'b0000, 1'b1, 1'b0, b});
    if (delay == 0) begin
      for (int j = 1; j <= BUSY_TIMEOUT; j++) begin
        tick();
        tx_busy = 1'b0;
        if (noise && !hold) begin
          req      = 4'($urandom);
          req_data = $urandom;
        end
        check_eq("wait_hi", {18'd0, obs()}, {18'd0, quiet(b)});
      end
      tick();
      check_eq("timeout", {18'd0, obs()}, {18'd0, 4'b0000, 1'b0, 1'b1, b});
    end else begin
      for (int j = 1; j <= delay + len; j++) begin
        tick();
        tx_busy = (j >= delay) && (j < delay + len);
        if (noise && !hold) begin
          req      = 4'($urandom);
          req_data = $urandom;
        end
        check_eq("in_flight", {18'd0, obs()}, {18'd0, quiet(b)});
      end
      tick();
      check_eq("idle_again", {18'd0, obs()}, {18'd0, quiet(b)});
    end
    if (!hold) req = 4'b0000;
  endtask

  // Sender busy while the arbiter is idle: requests must wait for it to clear.
  task automatic busy_in_idle(input int cycles, input logic [3:0] pat, input logic [31:0] data);
    tx_busy  = 1'b1;
    req      = pat;
    req_data = data;
    for (int i = 0; i < cycles; i++) begin
      tick();
      check_eq("busy_idle_ack", {27'd0, ack, tx_start}, 32'd0);
    end
    tx_busy = 1'b0;
  endtask

  // Start a transfer, advance 'extra' cycles past ISSUE with the sender busy,
  // then assert reset between clock edges.
  task automatic mid_reset(input int extra);
    req      = 4'($urandom_range(1, 15));
    req_data = $urandom;
    tick();
    tick();
    if (extra == 0) check_eq("pre_reset_start", {31'd0, tx_start}, 32'd1);
    req = 4'b0000;
    for (int i = 0; i < extra; i++) begin
      tick();
      tx_busy = 1'b1;
    end
    #2 rst_n = 1'b0;
    #1;
    check_eq("reset_async", {15'd0, obs(), active_id}, 32'd0);
    req = 4'b1111;
    tick();
    tick();
    check_eq("reset_held", {15'd0, obs(), active_id}, 32'd0);
    rst_n   = 1'b1;
    tx_busy = 1'b0;
    req     = 4'b0000;
    exp_ptr = 0;
  endtask

  initial begin
    logic [3:0]  pat;
    logic [31:0] data;
    int          dly;
    errors   = 0;
    checks   = 0;
    exp_ptr  = 0;
    rst_n    = 1'b1;
    req      = 4'b0000;
    req_data = 32'd0;
    tx_busy  = 1'b0;
    #2 rst_n = 1'b0;
    tick();
    tick();
    check_eq("reset_state", {15'd0, obs(), active_id}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single requester 2 with byte A5; the sender goes busy 3 cycles after the start strobe, for 10 cycles.
    run_xfer(4'b0100, 32'h00A5_0000, 3, 10, 1'b0, 1'b0);
    check_eq("single_data", {24'd0, tx_data}, 32'h0000_00A5);

    // Sender already busy in IDLE; req[0] must wait until busy falls.
    data = $urandom;
    busy_in_idle(4, 4'b0001, data);
    run_xfer(4'b0001, data, 2, 3, 1'b0, 1'b0);

    // Sender never goes busy, then a normal transfer follows.
    run_xfer(4'b0010, $urandom, 0, 0, 1'b1, 1'b0);
    run_xfer(4'b0010, $urandom, 2, 2, 1'b0, 1'b0);

    // Reset in the middle of WAIT_LO; the first grant afterwards goes to the lowest set request.
    mid_reset(3);
    run_xfer(4'b1010, $urandom, 1, 2, 1'b0, 1'b0);
    check_eq("post_reset_id", {29'd0, active_id}, 32'd1);

    // Reset while tx_start is high; the strobe must drop at once.
    mid_reset(0);

    // All four requesters held high: bytes 10, 11, 12, 13, then 10 again.
    for (int k = 0; k < 5; k++) begin
      run_xfer(4'b1111, 32'h1312_1110, $urandom_range(1, 5), $urandom_range(1, 4), 1'b0, 1'b1);
      check_eq("fair_seq", {24'd0, tx_data}, 32'h10 + 32'(k % 4));
    end
    req = 4'b0000;

    // Pointer is now 1: pattern 1001 must grant 3 first, then wrap to 0.
    run_xfer(4'b1001, $urandom, 1, 1, 1'b0, 1'b0);
    check_eq("wrap_first", {29'd0, active_id}, 32'd3);
    run_xfer(4'b1001, $urandom, 1, 1, 1'b0, 1'b0);
    check_eq("wrap_second", {29'd0, active_id}, 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      pat  = 4'($urandom_range(0, 15));
      data = $urandom;
      if ($urandom_range(0, 7) == 0) busy_in_idle($urandom_range(1, 4), pat, data);
      dly = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 14);
      run_xfer(pat, data, dly, $urandom_range(1, 6), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
